fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter DW, default 32: operand/data width.
REQ-002 Parameter AW, default 5: register address width.
REQ-003 Parameter NSTG, default 3: number of tracked stages after ID (stage 0 = E, stage NSTG-1 = W), range 2..8.
REQ-004 Parameter LD_STG, default 1: stage index where load data is first available on mem_data, range 0..NSTG-1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 id_valid  in  1  ID holds a valid instruction.
REQ-008 id_rs, id_rt  in  AW each  ID source register addresses.
REQ-009 use_a, use_b  in  1 each  ID actually reads rs / rt.
REQ-010 id_wr, id_ld  in  1 each  ID instruction writes a register / is a load.
REQ-011 id_dst  in  AW  ID destination address.
REQ-012 rf_a, rf_b  in  DW each  register-file read data for rs / rt.
REQ-013 stg_data  in  NSTG*DW  result bus per stage; stage i occupies bits [i*DW +: DW].
REQ-014 mem_data  in  DW  load data, valid for the entry at stage LD_STG.
REQ-015 br_en  in  1  ID instruction is a conditional branch.
REQ-016 br_op  in  3  000 EQ, 001 NE, 010 LEZ, 011 GTZ, 100 LTZ, 101 GEZ (signed, operand a vs zero); others never taken.
REQ-017 fwd_a, fwd_b  out  DW each  forwarded operands.
REQ-018 stall  out  1  hold IF/ID, inject bubble.
REQ-019 br_taken  out  1  branch resolved taken this cycle.
REQ-020 flush  out  1  registered one-cycle flush of the IF instruction.
REQ-021 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-022 Block SHALL keep a scoreboard of NSTG entries {v, dst, ld}, one per stage.
REQ-023 Each cycle entry i SHALL shift to i+1; entry NSTG-1 is discarded.
REQ-024 Entry 0 SHALL load {id_valid & id_wr & !stall, id_dst, id_ld}; a stall SHALL insert a bubble (v=0).
REQ-025 Entry i matches an operand when v=1, dst==addr, addr!=0; the lowest matching i wins.
REQ-026 Matched non-load entry: operand = stg_data[i].
REQ-027 Matched load entry: i<LD_STG -> operand unavailable; i==LD_STG -> mem_data; i>LD_STG -> stg_data[i].
REQ-028 No match or addr==0: operand = rf_a / rf_b.
REQ-029 fwd_a, fwd_b, stall, br_taken SHALL be combinational in the current cycle (zero latency).
REQ-030 stall SHALL be 1 when id_valid and (use_a with rs unavailable, or use_b with rt unavailable).
REQ-031 Stalls SHALL self-clear: a stall lasts at most LD_STG cycles.
REQ-032 br_taken = id_valid & br_en & !stall & compare(fwd_a, fwd_b, br_op); it is 0 during stall.
REQ-033 flush SHALL be br_taken registered: high exactly the cycle after br_taken.
REQ-034 stall_cnt SHALL increment on every stall cycle and hold at 16'hFFFF.
REQ-035 When stall and flush are both high, flush SHALL still be asserted; the scoreboard SHALL still bubble.

Reset
REQ-036 reset SHALL clear every scoreboard v, flush and stall_cnt on the next edge; reset wins over all events.
REQ-037 After reset, stall=0 and fwd_a/fwd_b = rf_a/rf_b until an entry is written.
REQ-038 Reset asserted mid-stall SHALL end the stall the following cycle.

Verification
REQ-039 Non-load producer: issue wr r3, then ID uses r3 with stg_data[0]=0x55 -> fwd_a=0x55, stall=0.
REQ-040 Load-use, defaults: issue load r4, next ID uses r4 -> stall=1 for exactly 1 cycle; next cycle fwd=mem_data, stall_cnt=1.
REQ-041 Priority: r5 present at stages 0 and 2 with stg_data 0x11 and 0x22 -> fwd=0x11.
REQ-042 r0 present at stage 0 with data 0x99, rf_a=0 -> fwd_a=0.
REQ-043 BEQ r1,r2 after r1 written with 7, rf_b=7 -> br_taken=1, flush=1 next cycle only; same branch during load-use stall -> br_taken=0 until stall clears.
REQ-044 Stall 70000 cycles forced -> stall_cnt=0xFFFF; reset pulse -> stall_cnt=0, all v=0.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if
//   Bundles the ID-stage operand/branch request, the per-stage result buses and
//   the forwarding/hazard responses of fwd_hazard_unit.
//   master : the pipeline side (drives ID fields, register-file data, stage data).
//   slave  : the forwarding/hazard unit (returns operands, stall, branch, flush).
//   Ports (signals):
//     id_valid, id_rs, id_rt, use_a, use_b, id_wr, id_ld, id_dst : ID instruction
//     rf_a, rf_b        : register-file read data for rs / rt
//     stg_data          : result bus per stage, stage i at [i*DW +: DW]
//     mem_data          : load data for the entry at stage LD_STG
//     br_en, br_op      : branch request and comparison code
//     fwd_a, fwd_b      : forwarded operands
//     stall, br_taken   : combinational hazard / branch outcome
//     flush             : registered flush, one cycle after br_taken
//     stall_cnt         : saturating stall-cycle count
interface fwd_hazard_unit_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NSTG = 3
);
    logic                 id_valid;
    logic [AW-1:0]        id_rs;
    logic [AW-1:0]        id_rt;
    logic                 use_a;
    logic                 use_b;
    logic                 id_wr;
    logic                 id_ld;
    logic [AW-1:0]        id_dst;
    logic [DW-1:0]        rf_a;
    logic [DW-1:0]        rf_b;
    logic [NSTG*DW-1:0]   stg_data;
    logic [DW-1:0]        mem_data;
    logic                 br_en;
    logic [2:0]           br_op;
    logic [DW-1:0]        fwd_a;
    logic [DW-1:0]        fwd_b;
    logic                 stall;
    logic                 br_taken;
    logic                 flush;
    logic [15:0]          stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, use_a, use_b, id_wr, id_ld, id_dst,
        output rf_a, rf_b, stg_data, mem_data, br_en, br_op,
        input  fwd_a, fwd_b, stall, br_taken, flush, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, use_a, use_b, id_wr, id_ld, id_dst,
        input  rf_a, rf_b, stg_data, mem_data, br_en, br_op,
        output fwd_a, fwd_b, stall, br_taken, flush, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand forwarding, load-use hazard detection and branch resolution for the
//   ID stage. A shift-register scoreboard records {valid, dst, is_load} for each
//   of the NSTG stages following ID; the youngest matching producer supplies the
//   operand. Loads whose data is not yet on mem_data cause a stall, during which
//   a bubble is shifted in so the stall clears by itself after LD_STG cycles.
//   Ports:
//     clk   : clock, all state on rising edge
//     reset : synchronous active-high reset
//     bus   : fwd_hazard_unit_if slave modport (see interface header)
module fwd_hazard_unit #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NSTG   = 3,
    parameter int LD_STG = 1
) (
    input  logic               clk,
    input  logic               reset,
    fwd_hazard_unit_if.slave   bus
);

    logic [NSTG-1:0] v_reg;
    logic [NSTG-1:0] ld_reg;
    logic [AW-1:0]   dst_reg [NSTG];
    logic            flush_reg;
    logic [15:0]     stall_cnt_reg;

    logic [NSTG-1:0] match_a;
    logic [NSTG-1:0] match_b;
    logic [DW:0]     res_a;     // {unavailable, value}
    logic [DW:0]     res_b;
    logic            stall_next;
    logic            br_taken_next;

    // Register 0 is hard-wired zero, so it never matches a producer.
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_match
        assign match_a[gi] = v_reg[gi] && (dst_reg[gi] == bus.id_rs) && (bus.id_rs != '0);
        assign match_b[gi] = v_reg[gi] && (dst_reg[gi] == bus.id_rt) && (bus.id_rt != '0);
    end

    // Walk from oldest to youngest so the lowest matching stage has the last word.
    function automatic logic [DW:0] resolve(
        input logic [NSTG-1:0]    m,
        input logic [NSTG-1:0]    ld,
        input logic [NSTG*DW-1:0] stg,
        input logic [DW-1:0]      mem,
        input logic [DW-1:0]      rf
    );
        logic [DW:0] r;
        r = {1'b0, rf};
        for (int i = NSTG - 1; i >= 0; i--) begin
            if (m[i]) begin
                if (!ld[i])
                    r = {1'b0, stg[i*DW +: DW]};
                else if (i < LD_STG)
                    r = {1'b1, stg[i*DW +: DW]};
                else if (i == LD_STG)
                    r = {1'b0, mem};
                else
                    r = {1'b0, stg[i*DW +: DW]};
            end
        end
        return r;
    endfunction

    function automatic logic br_compare(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [2:0]    op
    );
        logic a_neg;
        logic a_zero;
        a_neg  = a[DW-1];
        a_zero = (a == '0);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b010:  return a_neg || a_zero;
            3'b011:  return !a_neg && !a_zero;
            3'b100:  return a_neg;
            3'b101:  return !a_neg;
            default: return 1'b0;
        endcase
    endfunction

    assign res_a = resolve(match_a, ld_reg, bus.stg_data, bus.mem_data, bus.rf_a);
    assign res_b = resolve(match_b, ld_reg, bus.stg_data, bus.mem_data, bus.rf_b);

    assign stall_next    = bus.id_valid && ((bus.use_a && res_a[DW]) || (bus.use_b && res_b[DW]));
    assign br_taken_next = bus.id_valid && bus.br_en && !stall_next
                           && br_compare(res_a[DW-1:0], res_b[DW-1:0], bus.br_op);

    // Valid bits, flush and the counter carry reset; the payload fields do not
    // need it because nothing reads them while their valid bit is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_reg         <= '0;
            flush_reg     <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            v_reg     <= {v_reg[NSTG-2:0], bus.id_valid & bus.id_wr & ~stall_next};
            flush_reg <= br_taken_next;
            if (stall_next && (stall_cnt_reg != 16'hFFFF))
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        ld_reg     <= {ld_reg[NSTG-2:0], bus.id_ld};
        dst_reg[0] <= bus.id_dst;
        for (int i = 1; i < NSTG; i++)
            dst_reg[i] <= dst_reg[i-1];
    end

    assign bus.fwd_a     = res_a[DW-1:0];
    assign bus.fwd_b     = res_b[DW-1:0];
    assign bus.stall     = stall_next;
    assign bus.br_taken  = br_taken_next;
    assign bus.flush     = flush_reg;
    assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Directed bench for fwd_hazard_unit. dut uses the default geometry
//   (NSTG=3, LD_STG=1); dut2 uses NSTG=8, LD_STG=7 so long stall runs reach
//   counter saturation within a modest cycle count.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.DW(32), .AW(5), .NSTG(3)) bus ();
    fwd_hazard_unit_if #(.DW(32), .AW(5), .NSTG(8)) bus2 ();

    fwd_hazard_unit #(.DW(32), .AW(5), .NSTG(3), .LD_STG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    fwd_hazard_unit #(.DW(32), .AW(5), .NSTG(8), .LD_STG(7)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.slave)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic nop;
        bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0;
        bus.use_a = 1'b0; bus.use_b = 1'b0; bus.id_wr = 1'b0; bus.id_ld = 1'b0;
        bus.id_dst = '0; bus.br_en = 1'b0; bus.br_op = 3'b000;
    endtask

    task automatic issue(input logic [4:0] dst, input logic ld);
        nop();
        bus.id_valid = 1'b1; bus.id_wr = 1'b1; bus.id_ld = ld; bus.id_dst = dst;
    endtask

    task automatic use_regs(input logic [4:0] rs, input logic [4:0] rt,
                            input logic ua, input logic ub);
        nop();
        bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = rt;
        bus.use_a = ua; bus.use_b = ub;
    endtask

    task automatic do_reset;
        nop();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        bus.rf_a = 32'h1234; bus.rf_b = 32'h5678;
        use_regs(5'd3, 5'd4, 1'b1, 1'b1);
        #1;
        checks += 5;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h want 0", bus.stall); end
        if (bus.fwd_a !== 32'h1234) begin errors++; $display("FAIL reset_fwd_a got %0h want 1234", bus.fwd_a); end
        if (bus.fwd_b !== 32'h5678) begin errors++; $display("FAIL reset_fwd_b got %0h want 5678", bus.fwd_b); end
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0h want 0", bus.flush); end
        if (bus.stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0h want 0", bus.stall_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_nonload;
        do_reset();
        bus.stg_data = {32'h77, 32'h66, 32'h55};
        bus.rf_a = 32'hAAAA; bus.rf_b = 32'hBBBB;
        issue(5'd3, 1'b0);
        step();
        use_regs(5'd3, 5'd3, 1'b1, 1'b1);
        #1;
        checks += 3;
        if (bus.fwd_a !== 32'h55) begin errors++; $display("FAIL nl_stage0_a got %0h want 55", bus.fwd_a); end
        if (bus.fwd_b !== 32'h55) begin errors++; $display("FAIL nl_stage0_b got %0h want 55", bus.fwd_b); end
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL nl_stall got %0h want 0", bus.stall); end
        step();
        checks++;
        if (bus.fwd_a !== 32'h66) begin errors++; $display("FAIL nl_stage1 got %0h want 66", bus.fwd_a); end
        step();
        checks++;
        if (bus.fwd_a !== 32'h77) begin errors++; $display("FAIL nl_stage2 got %0h want 77", bus.fwd_a); end
        step();
        checks++;
        if (bus.fwd_a !== 32'hAAAA) begin errors++; $display("FAIL nl_retired got %0h want aaaa", bus.fwd_a); end
        $display("test_nonload done");
    endtask

    task automatic test_load_use;
        do_reset();
        bus.mem_data = 32'hDEAD;
        bus.stg_data = {32'h77, 32'h66, 32'h55};
        bus.rf_a = 32'hAAAA;
        issue(5'd4, 1'b1);
        step();
        use_regs(5'd4, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_unused got %0h want 0", bus.stall); end
        bus.use_a = 1'b1;
        #1;
        checks += 2;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0h want 1", bus.stall); end
        if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL lu_br got %0h want 0", bus.br_taken); end
        step();
        checks += 3;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_clear got %0h want 0", bus.stall); end
        if (bus.fwd_a !== 32'hDEAD) begin errors++; $display("FAIL lu_mem got %0h want dead", bus.fwd_a); end
        if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0h want 1", bus.stall_cnt); end
        step();
        checks += 2;
        if (bus.fwd_a !== 32'h77) begin errors++; $display("FAIL lu_stage2 got %0h want 77", bus.fwd_a); end
        if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold got %0h want 1", bus.stall_cnt); end
        $display("test_load_use done");
    endtask

    task automatic test_priority;
        do_reset();
        issue(5'd5, 1'b0); step();
        issue(5'd6, 1'b0); step();
        issue(5'd5, 1'b0); step();
        bus.stg_data = {32'h22, 32'h33, 32'h11};
        use_regs(5'd5, 5'd6, 1'b1, 1'b1);
        #1;
        checks += 2;
        if (bus.fwd_a !== 32'h11) begin errors++; $display("FAIL prio_a got %0h want 11", bus.fwd_a); end
        if (bus.fwd_b !== 32'h33) begin errors++; $display("FAIL prio_b got %0h want 33", bus.fwd_b); end
        $display("test_priority done");
    endtask

    task automatic test_r0;
        do_reset();
        bus.rf_a = 32'h0; bus.rf_b = 32'h0;
        bus.stg_data = {32'h0, 32'h0, 32'h99};
        issue(5'd0, 1'b0); step();
        use_regs(5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.fwd_a !== 32'h0) begin errors++; $display("FAIL r0_fwd got %0h want 0", bus.fwd_a); end
        do_reset();
        issue(5'd0, 1'b1); step();
        use_regs(5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_load_stall got %0h want 0", bus.stall); end
        $display("test_r0 done");
    endtask

    task automatic test_branch;
        logic [67:0] tbl [14];
        logic [67:0] row;
        do_reset();
        bus.stg_data = {32'h0, 32'h0, 32'h7};
        bus.rf_a = 32'h0; bus.rf_b = 32'h7;
        issue(5'd1, 1'b0); step();
        use_regs(5'd1, 5'd2, 1'b1, 1'b1);
        bus.br_en = 1'b1; bus.br_op = 3'b000;
        #1;
        checks += 2;
        if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %0h want 1", bus.br_taken); end
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL beq_noflush got %0h want 0", bus.flush); end
        step();
        nop();
        #1;
        checks += 2;
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL beq_flush got %0h want 1", bus.flush); end
        if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL beq_after got %0h want 0", bus.br_taken); end
        step();
        checks++;
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL beq_flush_once got %0h want 0", bus.flush); end

        // {op, a, b, expected} with an empty scoreboard, so operands come from rf.
        tbl = '{{3'd1, 32'd5, 32'd5, 1'b0}, {3'd1, 32'd5, 32'd6, 1'b1},
                {3'd2, 32'd0, 32'd0, 1'b1}, {3'd2, 32'd1, 32'd0, 1'b0},
                {3'd2, 32'h80000000, 32'd0, 1'b1}, {3'd3, 32'd1, 32'd0, 1'b1},
                {3'd3, 32'd0, 32'd0, 1'b0}, {3'd4, 32'hFFFFFFFF, 32'd0, 1'b1},
                {3'd4, 32'd0, 32'd0, 1'b0}, {3'd5, 32'd0, 32'd0, 1'b1},
                {3'd5, 32'h80000000, 32'd0, 1'b0}, {3'd6, 32'd0, 32'd0, 1'b0},
                {3'd7, 32'd5, 32'd5, 1'b0}, {3'd0, 32'd5, 32'd6, 1'b0}};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            row = tbl[i];
            use_regs(5'd1, 5'd2, 1'b1, 1'b1);
            bus.br_en = 1'b1;
            bus.br_op = row[67:65];
            bus.rf_a  = row[64:33];
            bus.rf_b  = row[32:1];
            #1;
            checks++;
            if (bus.br_taken !== row[0])
                begin errors++; $display("FAIL br_op%0d_row%0d got %0h want %0h", row[67:65], i, bus.br_taken, row[0]); end
        end

        do_reset();
        bus.mem_data = 32'h7; bus.rf_a = 32'h0; bus.rf_b = 32'h7;
        issue(5'd1, 1'b1); step();
        use_regs(5'd1, 5'd2, 1'b1, 1'b1);
        bus.br_en = 1'b1; bus.br_op = 3'b000;
        #1;
        checks += 2;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL brst_stall got %0h want 1", bus.stall); end
        if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL brst_hold got %0h want 0", bus.br_taken); end
        step();
        checks += 2;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL brst_clear got %0h want 0", bus.stall); end
        if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL brst_taken got %0h want 1", bus.br_taken); end
        step();
        nop();
        #1;
        checks++;
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL brst_flush got %0h want 1", bus.flush); end
        $display("test_branch done");
    endtask

    task automatic test_stall_flush;
        do_reset();
        bus.rf_a = 32'h0; bus.rf_b = 32'h0; bus.mem_data = 32'hCAFE;
        issue(5'd4, 1'b1);
        bus.br_en = 1'b1; bus.br_op = 3'b000;
        #1;
        checks++;
        if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL sf_taken got %0h want 1", bus.br_taken); end
        step();
        use_regs(5'd4, 5'd0, 1'b1, 1'b0);
        #1;
        checks += 2;
        if (bus.stall !== 1'b1) begin errors++; $display("FAIL sf_stall got %0h want 1", bus.stall); end
        if (bus.flush !== 1'b1) begin errors++; $display("FAIL sf_flush got %0h want 1", bus.flush); end
        step();
        checks += 3;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL sf_clear got %0h want 0", bus.stall); end
        if (bus.flush !== 1'b0) begin errors++; $display("FAIL sf_flush_end got %0h want 0", bus.flush); end
        if (bus.fwd_a !== 32'hCAFE) begin errors++; $display("FAIL sf_fwd got %0h want cafe", bus.fwd_a); end
        $display("test_stall_flush done");
    endtask

    // A load that also consumes its own destination keeps dut2 stalling
    // 7 cycles out of every 8 (cycle k stalls unless k % 8 == 0).
    task automatic test_saturation;
        bus2.rf_a = 32'h1357; bus2.rf_b = 32'h0; bus2.stg_data = '0; bus2.mem_data = '0;
        bus2.id_valid = 1'b1; bus2.id_rs = 5'd4; bus2.id_rt = 5'd0;
        bus2.use_a = 1'b1; bus2.use_b = 1'b0; bus2.id_wr = 1'b1; bus2.id_ld = 1'b1;
        bus2.id_dst = 5'd4; bus2.br_en = 1'b0; bus2.br_op = 3'b000;
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        repeat (8000) step();
        checks++;
        if (bus2.stall_cnt !== 16'd7000) begin errors++; $display("FAIL sat_partial got %0d want 7000", bus2.stall_cnt); end
        repeat (67001) step();
        checks += 2;
        if (bus2.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_full got %0h want ffff", bus2.stall_cnt); end
        if (bus2.stall !== 1'b1) begin errors++; $display("FAIL sat_midstall got %0h want 1", bus2.stall); end
        reset2 = 1'b1;
        step();
        checks += 4;
        if (bus2.stall_cnt !== 16'h0) begin errors++; $display("FAIL sat_reset_cnt got %0h want 0", bus2.stall_cnt); end
        if (bus2.stall !== 1'b0) begin errors++; $display("FAIL sat_reset_stall got %0h want 0", bus2.stall); end
        if (bus2.fwd_a !== 32'h1357) begin errors++; $display("FAIL sat_reset_fwd got %0h want 1357", bus2.fwd_a); end
        if (bus2.flush !== 1'b0) begin errors++; $display("FAIL sat_reset_flush got %0h want 0", bus2.flush); end
        $display("test_saturation done");
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        nop();
        bus.rf_a = '0; bus.rf_b = '0; bus.stg_data = '0; bus.mem_data = '0;
        bus2.id_valid = 1'b0; bus2.id_rs = '0; bus2.id_rt = '0; bus2.use_a = 1'b0;
        bus2.use_b = 1'b0; bus2.id_wr = 1'b0; bus2.id_ld = 1'b0; bus2.id_dst = '0;
        bus2.rf_a = '0; bus2.rf_b = '0; bus2.stg_data = '0; bus2.mem_data = '0;
        bus2.br_en = 1'b0; bus2.br_op = 3'b000;
        step();
        test_reset();
        test_nonload();
        test_load_use();
        test_priority();
        test_r0();
        test_branch();
        test_stall_flush();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
